kbd_event_decoder: RTL and testbench
====================================

Name: kbd_event_decoder

Overview:
Consumes raw PS/2 scancode bytes from the keyboard receiver FIFO (data/ready/nextdata_n handshake) and turns them into key events. Resolves E0 (extended) and F0 (break) prefixes, filters typematic repeats, and tracks modifier and Caps Lock state. Emits one registered event per non-prefix byte to the ASCII-conversion and display stages.

Parameters:
CNT_W, 8, width of press counter (wraps)

Ports:
clk  in  1  system clock
clrn  in  1  synchronous active-low reset
kb_data  in  8  FIFO head byte, valid while kb_ready=1
kb_ready  in  1  FIFO non-empty
kb_nextdata_n  out  1  active-low pop strobe to FIFO, one cycle wide
key_valid  out  1  one-cycle event strobe
key_code  out  8  scancode of event (prefixes stripped)
key_ext  out  1  event was E0-prefixed
key_release  out  1  event is a break (F0-prefixed)
key_repeat  out  1  make of key already held (typematic)
key_held  out  1  a non-modifier key is currently held
shift  out  1  left (12) or right (59) shift held
ctrl  out  1  left (14) or right (E0 14) ctrl held
alt  out  1  left (11) or right (E0 11) alt held
caps_lock  out  1  Caps Lock toggle state
press_count  out  CNT_W  count of non-repeat makes of non-modifier keys

Behaviour:
- Reset (clrn=0 at posedge clk): kb_nextdata_n=1, every other output 0; internal ext_pend/brk_pend=0; held key record cleared; state=IDLE. Reset has priority over all events, including mid-sequence (after E0 or F0) and mid-pop.
- FSM: IDLE, POP, GAP.
  - IDLE: if kb_ready=1 at edge N, then byte is sampled and decoded; kb_nextdata_n<=0; state<=POP. Otherwise stay; kb_nextdata_n=1.
  - POP: kb_nextdata_n<=1; key_valid<=0; state<=GAP.
  - GAP: state<=IDLE. This gives the FIFO pointer one settle cycle. kb_ready is ignored in POP and GAP.
  - Throughput is 1 byte per 3 clocks. Exactly one pop per byte; never pop when kb_ready=0.
- Decode at edge N, by sampled byte b:
  - E0: ext_pend<=1; no event.
  - F0: brk_pend<=1; no event.
  - 00 or FF (receiver error/overrun): clear ext_pend and brk_pend; no event.
  - Any other byte: key_valid<=1 for the cycle after N.
    - key_code<=b, key_ext<=ext_pend, key_release<=brk_pend.
    - Clear ext_pend and brk_pend.
- Modifiers, keyed on {ext,code}:
  - {0,12}=lshift, {0,59}=rshift, {0,14}=lctrl, {1,14}=rctrl, {0,11}=lalt, {1,11}=ralt.
  - Make sets the individual register; break clears it.
  - shift/ctrl/alt outputs are the OR of the left and right registers.
  - Modifier events still pulse key_valid but never touch held record or press_count.
- Caps Lock {0,58}: non-repeat make toggles caps_lock. Repeats and breaks do not toggle.
- Held record, non-modifier keys only:
  - Make matching the held {ext,code} while key_held=1: key_repeat=1, no count.
  - Any other make: key_repeat=0, held<={ext,code}, key_held<=1, press_count<=press_count+1 (wraps 2^CNT_W-1 to 0).
  - Break matching held: key_held<=0.
  - Break not matching: no change to held.
  - key_repeat is always 0 on breaks.
- key_code/key_ext/key_release/key_repeat hold their values between events; only key_valid pulses.

Test Plan:
- Reset then byte 1C (A make): key_valid one cycle, key_code=1C, ext=0, release=0, press_count=1, key_held=1. kb_nextdata_n low exactly one cycle, 1 clock after kb_ready seen.
- Bytes 1C,1C,1C then F0,1C: three events with key_repeat=0,1,1; press_count=1. Break event release=1; key_held=0.
- Bytes 12,1C,F0,1C,F0,12: shift=1 after first event. A events seen with shift=1. shift=0 only after final F0 12. press_count=1.
- Bytes E0,14 then E0,F0,14: ctrl=1 then 0. Events carry key_ext=1. Prefix bytes produce no key_valid.
- Bytes 58,F0,58,58,58(repeat),F0,58: caps_lock goes 1 then 0. Repeat does not toggle.
- Edge cases:
  - Assert clrn=0 after E0,F0, then send 1C: event has ext=0, release=0.
  - Send 256 distinct make/break pairs: press_count wraps to 0.
  - Drive kb_ready=0: kb_nextdata_n stays 1.

Source files
------------

// File: rtl/kbd_event_decoder.sv
// ---------------------------------------------------------------------------
// kbd_event_decoder
//
// Turns raw PS/2 scancode bytes from the keyboard receiver FIFO into key
// events. E0 (extended) and F0 (break) prefixes are folded into the event
// that follows them. Typematic repeats are flagged. Modifier and Caps Lock
// state are tracked.
//
// Each byte is handled in three clocks: sample/decode, pop, settle gap.
//
// Ports
//   clk            in   system clock
//   clrn           in   synchronous active-low reset
//   kb_data[7:0]   in   FIFO head byte, valid while kb_ready=1
//   kb_ready       in   FIFO non-empty
//   kb_nextdata_n  out  active-low FIFO pop strobe, one cycle wide
//   key_valid      out  one-cycle event strobe
//   key_code[7:0]  out  scancode of the event, with prefixes stripped
//   key_ext        out  event was E0-prefixed
//   key_release    out  event is a break (F0-prefixed)
//   key_repeat     out  make of the key that is already held (typematic)
//   key_held       out  a non-modifier key is currently held
//   shift/ctrl/alt out  modifier held (left OR right)
//   caps_lock      out  Caps Lock toggle state
//   press_count    out  count of non-repeat makes of non-modifier keys
// ---------------------------------------------------------------------------
module kbd_event_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   output logic             kb_nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_release,
   output logic             key_repeat,
   output logic             key_held,
   output logic             shift,
   output logic             ctrl,
   output logic             alt,
   output logic             caps_lock,
   output logic [CNT_W-1:0] press_count
);

   typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

   // Keys are identified as {ext, code}.
   localparam logic [8:0] K_LSHIFT = 9'h012;
   localparam logic [8:0] K_RSHIFT = 9'h059;
   localparam logic [8:0] K_LCTRL  = 9'h014;
   localparam logic [8:0] K_RCTRL  = 9'h114;
   localparam logic [8:0] K_LALT   = 9'h011;
   localparam logic [8:0] K_RALT   = 9'h111;
   localparam logic [8:0] K_CAPS   = 9'h058;

   state_t           state_q, state_d;
   logic             pop_n_q, pop_n_d;
   logic             valid_q, valid_d;
   logic [7:0]       code_q, code_d;
   logic             ext_q, ext_d;
   logic             rel_q, rel_d;
   logic             rep_q, rep_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic             held_q, held_d;
   logic [8:0]       held_key_q, held_key_d;
   logic             lshift_q, lshift_d;
   logic             rshift_q, rshift_d;
   logic             lctrl_q, lctrl_d;
   logic             rctrl_q, rctrl_d;
   logic             lalt_q, lalt_d;
   logic             ralt_q, ralt_d;
   logic             caps_q, caps_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [8:0]       key9;
   logic             is_mod;
   logic             held_match;

   assign key9       = {ext_pend_q, kb_data};
   assign is_mod     = (key9 == K_LSHIFT) || (key9 == K_RSHIFT) ||
                       (key9 == K_LCTRL)  || (key9 == K_RCTRL)  ||
                       (key9 == K_LALT)   || (key9 == K_RALT);
   assign held_match = held_q && (held_key_q == key9);

   always_comb begin
      state_d    = state_q;
      pop_n_d    = pop_n_q;
      valid_d    = valid_q;
      code_d     = code_q;
      ext_d      = ext_q;
      rel_d      = rel_q;
      rep_d      = rep_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      held_d     = held_q;
      held_key_d = held_key_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      lctrl_d    = lctrl_q;
      rctrl_d    = rctrl_q;
      lalt_d     = lalt_q;
      ralt_d     = ralt_q;
      caps_d     = caps_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            pop_n_d = 1'b1;
            if (kb_ready) begin
               pop_n_d = 1'b0;
               state_d = POP;
               case (kb_data)
                  8'hE0: ext_pend_d = 1'b1;
                  8'hF0: brk_pend_d = 1'b1;
                  // Receiver error/overrun: drop any half-built sequence.
                  8'h00, 8'hFF: begin
                     ext_pend_d = 1'b0;
                     brk_pend_d = 1'b0;
                  end
                  default: begin
                     valid_d    = 1'b1;
                     code_d     = kb_data;
                     ext_d      = ext_pend_q;
                     rel_d      = brk_pend_q;
                     rep_d      = 1'b0;
                     ext_pend_d = 1'b0;
                     brk_pend_d = 1'b0;
                     if (is_mod) begin
                        // Make sets, break clears; modifiers never touch
                        // the held record or the press counter.
                        case (key9)
                           K_LSHIFT: lshift_d = ~brk_pend_q;
                           K_RSHIFT: rshift_d = ~brk_pend_q;
                           K_LCTRL:  lctrl_d  = ~brk_pend_q;
                           K_RCTRL:  rctrl_d  = ~brk_pend_q;
                           K_LALT:   lalt_d   = ~brk_pend_q;
                           K_RALT:   ralt_d   = ~brk_pend_q;
                           default:  ;
                        endcase
                     end else if (!brk_pend_q) begin
                        if (held_match) begin
                           rep_d = 1'b1;
                        end else begin
                           held_d     = 1'b1;
                           held_key_d = key9;
                           cnt_d      = cnt_q + 1'b1;
                           if (key9 == K_CAPS) begin
                              caps_d = ~caps_q;
                           end
                        end
                     end else if (held_match) begin
                        // A break for some other key leaves the record alone.
                        held_d = 1'b0;
                     end
                  end
               endcase
            end
         end
         POP: begin
            pop_n_d = 1'b1;
            valid_d = 1'b0;
            state_d = GAP;
         end
         GAP: begin
            // One settle cycle for the FIFO read pointer; kb_ready ignored.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q    <= IDLE;
         pop_n_q    <= 1'b1;
         valid_q    <= 1'b0;
         code_q     <= 8'h00;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         rep_q      <= 1'b0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         held_q     <= 1'b0;
         held_key_q <= 9'h000;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         lctrl_q    <= 1'b0;
         rctrl_q    <= 1'b0;
         lalt_q     <= 1'b0;
         ralt_q     <= 1'b0;
         caps_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pop_n_q    <= pop_n_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         rep_q      <= rep_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         held_q     <= held_d;
         held_key_q <= held_key_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         lctrl_q    <= lctrl_d;
         rctrl_q    <= rctrl_d;
         lalt_q     <= lalt_d;
         ralt_q     <= ralt_d;
         caps_q     <= caps_d;
         cnt_q      <= cnt_d;
      end
   end

   assign kb_nextdata_n = pop_n_q;
   assign key_valid     = valid_q;
   assign key_code      = code_q;
   assign key_ext       = ext_q;
   assign key_release   = rel_q;
   assign key_repeat    = rep_q;
   assign key_held      = held_q;
   assign shift         = lshift_q | rshift_q;
   assign ctrl          = lctrl_q | rctrl_q;
   assign alt           = lalt_q | ralt_q;
   assign caps_lock     = caps_q;
   assign press_count   = cnt_q;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_kbd_event_decoder
//
// Directed scancode sequences. The stimulus pushes the expected event for
// every non-prefix byte into a queue; an independent monitor pops and
// compares whenever key_valid is seen. The FIFO handshake (pop latency,
// pop width, no pop while empty) and reset values are checked inline.
// ---------------------------------------------------------------------------
module tb_kbd_event_decoder;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext, key_release, key_repeat, key_held;
   logic       shift, ctrl, alt, caps_lock;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic       rep;
      logic       held;
      logic       sh;
      logic       ct;
      logic       al;
      logic       caps;
      logic [7:0] cnt;
   } ev_t;

   ev_t exp_q[$];

   always #5 clk = ~clk;

   kbd_event_decoder #(.CNT_W(8)) dut (
      .clk           (clk),
      .clrn          (clrn),
      .kb_data       (kb_data),
      .kb_ready      (kb_ready),
      .kb_nextdata_n (kb_nextdata_n),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .key_ext       (key_ext),
      .key_release   (key_release),
      .key_repeat    (key_repeat),
      .key_held      (key_held),
      .shift         (shift),
      .ctrl          (ctrl),
      .alt           (alt),
      .caps_lock     (caps_lock),
      .press_count   (press_count)
   );

   // Monitor: one line per observed event.
   always @(negedge clk) begin
      if (clrn && key_valid) begin
         ev_t act;
         ev_t exp_e;
         act = {key_code, key_ext, key_release, key_repeat, key_held,
                shift, ctrl, alt, caps_lock, press_count};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got %h (none expected)", act);
         end else begin
            exp_e = exp_q.pop_front();
            if (act !== exp_e) begin
               errors++;
               $display("FAIL event got %h expected %h", act, exp_e);
            end else begin
               $display("event code=%h ext=%b rel=%b rep=%b held=%b sh=%b ct=%b al=%b caps=%b cnt=%0d",
                        key_code, key_ext, key_release, key_repeat, key_held,
                        shift, ctrl, alt, caps_lock, press_count);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      kb_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state",
          {6'd0, kb_nextdata_n, key_valid, key_code, key_ext, key_release, key_repeat,
           key_held, shift, ctrl, alt, caps_lock, press_count},
          32'h0200_0000);
      clrn = 1'b1;
      @(negedge clk);
   endtask

   // Present one byte at the FIFO head and see it popped exactly once.
   task automatic send(input logic [7:0] b);
      int waited;
      kb_data  = b;
      kb_ready = 1'b1;
      @(negedge clk);
      chk("pop_latency", {31'd0, kb_nextdata_n}, 32'd0);
      waited = 0;
      while (kb_nextdata_n !== 1'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (kb_nextdata_n !== 1'b0) begin
         errors++;
         $display("FAIL pop_timeout got nextdata_n=%b expected 0", kb_nextdata_n);
      end
      @(negedge clk);
      kb_ready = 1'b0;
      chk("pop_width", {31'd0, kb_nextdata_n}, 32'd1);
      @(negedge clk);
   endtask

   task automatic ev(input logic [7:0] b, input logic e, input logic r, input logic rp,
                     input logic h, input logic s, input logic c, input logic a,
                     input logic cp, input logic [7:0] n);
      exp_q.push_back({b, e, r, rp, h, s, c, a, cp, n});
      send(b);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Single A make.
      //  code   ext rel rep held sh ct al cp cnt
      ev(8'h1C, 0,  0,  0,  1,   0, 0, 0, 0, 8'd1);

      // Typematic repeats then break.
      do_reset();
      ev(8'h1C, 0, 0, 0, 1, 0, 0, 0, 0, 8'd1);
      ev(8'h1C, 0, 0, 1, 1, 0, 0, 0, 0, 8'd1);
      ev(8'h1C, 0, 0, 1, 1, 0, 0, 0, 0, 8'd1);
      send(8'hF0);
      ev(8'h1C, 0, 1, 0, 0, 0, 0, 0, 0, 8'd1);

      // Shift held around an A press.
      do_reset();
      ev(8'h12, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0);
      ev(8'h1C, 0, 0, 0, 1, 1, 0, 0, 0, 8'd1);
      send(8'hF0);
      ev(8'h1C, 0, 1, 0, 0, 1, 0, 0, 0, 8'd1);
      send(8'hF0);
      ev(8'h12, 0, 1, 0, 0, 0, 0, 0, 0, 8'd1);

      // Right ctrl, right shift.
      do_reset();
      send(8'hE0);
      ev(8'h14, 1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
      send(8'hE0); send(8'hF0);
      ev(8'h14, 1, 1, 0, 0, 0, 0, 0, 0, 8'd0);
      ev(8'h59, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0);
      send(8'hF0);
      ev(8'h59, 0, 1, 0, 0, 0, 0, 0, 0, 8'd0);

      // Caps Lock toggling, repeat does not toggle.
      do_reset();
      ev(8'h58, 0, 0, 0, 1, 0, 0, 0, 1, 8'd1);
      send(8'hF0);
      ev(8'h58, 0, 1, 0, 0, 0, 0, 0, 1, 8'd1);
      ev(8'h58, 0, 0, 0, 1, 0, 0, 0, 0, 8'd2);
      ev(8'h58, 0, 0, 1, 1, 0, 0, 0, 0, 8'd2);
      send(8'hF0);
      ev(8'h58, 0, 1, 0, 0, 0, 0, 0, 0, 8'd2);

      // Both alts, error byte clears a pending prefix, foreign break.
      do_reset();
      send(8'hE0);
      ev(8'h11, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0);
      ev(8'h11, 0, 0, 0, 0, 0, 0, 1, 0, 8'd0);
      send(8'hE0); send(8'hF0);
      ev(8'h11, 1, 1, 0, 0, 0, 0, 1, 0, 8'd0);
      send(8'hF0);
      ev(8'h11, 0, 1, 0, 0, 0, 0, 0, 0, 8'd0);
      send(8'hE0); send(8'hFF);
      ev(8'h1C, 0, 0, 0, 1, 0, 0, 0, 0, 8'd1);
      send(8'hF0); send(8'h00);
      ev(8'h1C, 0, 0, 1, 1, 0, 0, 0, 0, 8'd1);
      send(8'hF0);
      ev(8'h1D, 0, 1, 0, 1, 0, 0, 0, 0, 8'd1);
      ev(8'h1C, 0, 0, 1, 1, 0, 0, 0, 0, 8'd1);
      ev(8'h32, 0, 0, 0, 1, 0, 0, 0, 0, 8'd2);

      // Reset in the middle of an E0 F0 sequence.
      do_reset();
      send(8'hE0); send(8'hF0);
      do_reset();
      ev(8'h1C, 0, 0, 0, 1, 0, 0, 0, 0, 8'd1);

      // 256 make/break pairs: press counter wraps to zero.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] c;
         logic [7:0] n;
         c = 8'h20 + 8'(i % 32);
         n = 8'(i + 1);
         ev(c, 0, 0, 0, 1, 0, 0, 0, 0, n);
         send(8'hF0);
         ev(c, 0, 1, 0, 0, 0, 0, 0, 0, n);
      end
      chk("count_wrap", {24'd0, press_count}, 32'd0);

      // Empty FIFO: no pop strobe, no events.
      kb_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_no_pop", {30'd0, kb_nextdata_n, key_valid}, 32'd2);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
